// File: rtl/ptp_pulse_gen_pkg.sv
// ptp_pulse_gen_pkg: shared constants and channel state
// encoding for the RTC pulse generator.
package ptp_pulse_gen_pkg;

   localparam int unsigned NS_PER_SEC      = 1_000_000_000;
   localparam int unsigned PPS_PERIOD_CODE = 0;

   // CH_CFG register block layout (byte offsets)
   localparam logic [11:0] CH_CFG_BASE     = 12'h100;
   localparam logic [11:0] CH_CFG_STRIDE   = 12'h020;
   localparam logic [11:0] CH_CFG_CTRL     = 12'h000;
   localparam logic [11:0] CH_CFG_SC_LO    = 12'h004;
   localparam logic [11:0] CH_CFG_SC_HI    = 12'h008;
   localparam logic [11:0] CH_CFG_NS       = 12'h00C;
   localparam logic [11:0] CH_CFG_PERIOD   = 12'h010;
   localparam logic [11:0] CH_CFG_WIDTH    = 12'h014;
   localparam logic [11:0] CH_CFG_STATUS   = 12'h018;

   typedef enum logic [1:0] {
      CH_IDLE,
      CH_ARMED,
      CH_HIGH,
      CH_CATCHUP
   } ch_state_e;

endpackage

// File: rtl/ptp_pulse_gen_chan.sv
// ptp_pulse_gen_chan: one pulse channel, with its own
// {sec,ns} adder, comparators and sequencing FSM.
module ptp_pulse_gen_chan
   import ptp_pulse_gen_pkg::*;
#(
   parameter int          SEC_W  = 48,
   parameter int          NS_W   = 32,
   parameter int unsigned NS_MAX = 999_999_999
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SEC_W+NS_W-1:0]   rtc,
   input  logic                    step,
   input  logic                    en,
   input  logic                    load,
   input  logic                    cfg_ok,
   input  logic [SEC_W-1:0]        cfg_sc,
   input  logic [NS_W-1:0]         cfg_ns,
   input  logic [NS_W-1:0]         cfg_period,
   input  logic [NS_W-1:0]         cfg_width,
   output logic                    pulse,
   output logic                    evt,
   output logic                    missed,
   output logic                    cfg_err
);

   localparam int T_W = SEC_W + NS_W;
   localparam logic [NS_W:0]   NS_SEC_X = (NS_W+1)'(NS_PER_SEC);
   localparam logic [NS_W:0]   NS_TOP_X = (NS_W+1)'(NS_MAX);
   localparam logic [NS_W-1:0] NS_SEC   = NS_W'(NS_PER_SEC);
   localparam logic [NS_W-1:0] PPS_CODE = NS_W'(PPS_PERIOD_CODE);

   // ns + d with a single carry into seconds; d never
   // exceeds one second so one correction is enough
   function automatic logic [T_W-1:0] time_add(
      input logic [T_W-1:0]  t,
      input logic [NS_W-1:0] d
   );
      logic [SEC_W-1:0] sec;
      logic [NS_W:0]    sum;
      sec = t[T_W-1:NS_W];
      sum = {1'b0, t[NS_W-1:0]} + {1'b0, d};
      if (sum > NS_TOP_X) begin
         sum = sum - NS_SEC_X;
         sec = sec + SEC_W'(1);
      end
      return {sec, sum[NS_W-1:0]};
   endfunction

   ch_state_e        state_q, state_d;
   logic [T_W-1:0]   nr_q, nr_d;
   logic [T_W-1:0]   fall_q, fall_d;
   logic             pulse_q, pulse_d;
   logic             evt_q, evt_d;
   logic             missed_q, missed_d;
   logic             err_q, err_d;
   logic             en_q;

   logic [SEC_W-1:0] sc_q;
   logic [NS_W-1:0]  ns_q;
   logic [NS_W-1:0]  per_q;
   logic [NS_W-1:0]  wid_q;
   logic             ok_q;

   logic [NS_W-1:0]  per_eff;
   logic [T_W-1:0]   nr_next;
   logic [T_W-1:0]   fall_calc;
   logic             rise_hit;
   logic             fall_hit;

   assign per_eff   = (per_q == PPS_CODE) ? NS_SEC : per_q;
   assign nr_next   = time_add(nr_q, per_eff);
   assign fall_calc = time_add(nr_q, wid_q);
   assign rise_hit  = (rtc >= nr_q);
   assign fall_hit  = (rtc >= fall_q) || (wid_q == '0);

   // next-state: en=0 > load > step > normal sequencing
   always_comb begin
      state_d  = state_q;
      nr_d     = nr_q;
      fall_d   = fall_q;
      pulse_d  = pulse_q;
      evt_d    = 1'b0;
      missed_d = missed_q;
      err_d    = err_q;
      if (load) begin
         missed_d = 1'b0;
         err_d    = !cfg_ok;
      end
      if (!en) begin
         state_d = CH_IDLE;
         pulse_d = 1'b0;
      end else if (load) begin
         pulse_d = 1'b0;
         if (cfg_ok) begin
            nr_d    = {cfg_sc, cfg_ns};
            state_d = CH_ARMED;
         end else begin
            state_d = CH_IDLE;
         end
      end else if (step && state_q != CH_IDLE) begin
         // a pulse in flight is consumed; CATCHUP then
         // re-checks the target against the new time
         pulse_d = 1'b0;
         state_d = CH_CATCHUP;
         if (state_q == CH_HIGH) nr_d = nr_next;
      end else begin
         unique case (state_q)
            CH_IDLE: begin
               if (!en_q && ok_q) begin
                  nr_d    = {sc_q, ns_q};
                  state_d = CH_ARMED;
               end
            end
            CH_ARMED: begin
               if (rise_hit) begin
                  pulse_d = 1'b1;
                  evt_d   = 1'b1;
                  fall_d  = fall_calc;
                  state_d = CH_HIGH;
               end
            end
            CH_HIGH: begin
               if (fall_hit) begin
                  pulse_d = 1'b0;
                  nr_d    = nr_next;
                  state_d = (nr_next <= rtc) ? CH_CATCHUP
                                             : CH_ARMED;
               end
            end
            CH_CATCHUP: begin
               if (nr_q <= rtc) begin
                  nr_d     = nr_next;
                  missed_d = 1'b1;
               end else begin
                  state_d = CH_ARMED;
               end
            end
            default: state_d = CH_IDLE;
         endcase
      end
   end

   // channel state and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= CH_IDLE;
         nr_q     <= '0;
         fall_q   <= '0;
         pulse_q  <= 1'b0;
         evt_q    <= 1'b0;
         missed_q <= 1'b0;
         err_q    <= 1'b0;
         en_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         nr_q     <= nr_d;
         fall_q   <= fall_d;
         pulse_q  <= pulse_d;
         evt_q    <= evt_d;
         missed_q <= missed_d;
         err_q    <= err_d;
         en_q     <= en;
      end
   end

   // latched config; all-zero config is a legal PPS setup
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_q  <= '0;
         ns_q  <= '0;
         per_q <= '0;
         wid_q <= '0;
         ok_q  <= 1'b1;
      end else if (load) begin
         sc_q  <= cfg_sc;
         ns_q  <= cfg_ns;
         per_q <= cfg_period;
         wid_q <= cfg_width;
         ok_q  <= cfg_ok;
      end
   end

   assign pulse   = pulse_q;
   assign evt     = evt_q;
   assign missed  = missed_q;
   assign cfg_err = err_q;

endmodule

// File: rtl/ptp_pulse_gen.sv
// ptp_pulse_gen: NCH independent RTC-timed pulse channels
// sharing one config bus and the PTP time.
module ptp_pulse_gen
   import ptp_pulse_gen_pkg::*;
#(
   parameter int          NCH    = 4,
   parameter int          SEC_W  = 48,
   parameter int          NS_W   = 32,
   parameter int unsigned NS_MAX = 999_999_999
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEC_W+NS_W-1:0] rtc_std_i,
   input  logic                  rtc_step_i,
   input  logic [NCH-1:0]        ch_en_i,
   input  logic [NCH-1:0]        ch_load_i,
   input  logic [SEC_W-1:0]      cfg_sc_i,
   input  logic [NS_W-1:0]       cfg_ns_i,
   input  logic [NS_W-1:0]       cfg_period_i,
   input  logic [NS_W-1:0]       cfg_width_i,
   output logic [NCH-1:0]        pulse_o,
   output logic [NCH-1:0]        evt_o,
   output logic [NCH-1:0]        missed_o,
   output logic [NCH-1:0]        cfg_err_o
);

   localparam logic [NS_W-1:0] NS_SEC   = NS_W'(NS_PER_SEC);
   localparam logic [NS_W-1:0] NS_TOP   = NS_W'(NS_MAX);
   localparam logic [NS_W-1:0] PPS_CODE = NS_W'(PPS_PERIOD_CODE);

   logic [NS_W-1:0] per_eff;
   logic            cfg_ok;

   // legality is judged once on the shared config bus
   assign per_eff = (cfg_period_i == PPS_CODE) ? NS_SEC
                                               : cfg_period_i;
   assign cfg_ok  = (cfg_ns_i <= NS_TOP)
                 && (cfg_period_i <= NS_TOP)
                 && (cfg_width_i < per_eff);

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      ptp_pulse_gen_chan #(
         .SEC_W  (SEC_W),
         .NS_W   (NS_W),
         .NS_MAX (NS_MAX)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .rtc        (rtc_std_i),
         .step       (rtc_step_i),
         .en         (ch_en_i[g]),
         .load       (ch_load_i[g]),
         .cfg_ok     (cfg_ok),
         .cfg_sc     (cfg_sc_i),
         .cfg_ns     (cfg_ns_i),
         .cfg_period (cfg_period_i),
         .cfg_width  (cfg_width_i),
         .pulse      (pulse_o[g]),
         .evt        (evt_o[g]),
         .missed     (missed_o[g]),
         .cfg_err    (cfg_err_o[g])
      );
   end

endmodule

// File: tb/tb_ptp_pulse_gen.sv
// tb_ptp_pulse_gen: directed bench for the pulse generator,
// driving PTP time directly from a simple {sec,ns} model.
module tb_ptp_pulse_gen;

   localparam int NCH   = 4;
   localparam int SEC_W = 48;
   localparam int NS_W  = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [SEC_W-1:0]  t_sec;
   logic [NS_W-1:0]   t_ns;
   logic [NS_W-1:0]   inc;
   logic              rtc_step;
   logic [NCH-1:0]    ch_en;
   logic [NCH-1:0]    ch_load;
   logic [SEC_W-1:0]  cfg_sc;
   logic [NS_W-1:0]   cfg_ns;
   logic [NS_W-1:0]   cfg_period;
   logic [NS_W-1:0]   cfg_width;
   logic [NCH-1:0]    pulse_o;
   logic [NCH-1:0]    evt_o;
   logic [NCH-1:0]    missed_o;
   logic [NCH-1:0]    cfg_err_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ptp_pulse_gen #(
      .NCH   (NCH),
      .SEC_W (SEC_W),
      .NS_W  (NS_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rtc_std_i    ({t_sec, t_ns}),
      .rtc_step_i   (rtc_step),
      .ch_en_i      (ch_en),
      .ch_load_i    (ch_load),
      .cfg_sc_i     (cfg_sc),
      .cfg_ns_i     (cfg_ns),
      .cfg_period_i (cfg_period),
      .cfg_width_i  (cfg_width),
      .pulse_o      (pulse_o),
      .evt_o        (evt_o),
      .missed_o     (missed_o),
      .cfg_err_o    (cfg_err_o)
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic adv();
      t_ns = t_ns + inc;
      if (t_ns > 999_999_999) begin
         t_ns  = t_ns - 1_000_000_000;
         t_sec = t_sec + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ch_load  = '0;
      rtc_step = 1'b0;
      adv();
   endtask

   task automatic setcfg(input logic [SEC_W-1:0] sc,
                         input logic [NS_W-1:0] ns,
                         input logic [NS_W-1:0] per,
                         input logic [NS_W-1:0] wid);
      cfg_sc     = sc;
      cfg_ns     = ns;
      cfg_period = per;
      cfg_width  = wid;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int ne;
      int nh;
      int dbl;
      logic pp;
      logic found;
      logic [NS_W-1:0] pns;

      rst_n    = 1'b0;
      t_sec    = '0;
      t_ns     = '0;
      inc      = '0;
      rtc_step = 1'b0;
      ch_en    = '0;
      ch_load  = '0;
      setcfg('0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pulse", pulse_o, 0);
      chk("rst_evt", evt_o, 0);
      chk("rst_missed", missed_o, 0);
      chk("rst_cfg_err", cfg_err_o, 0);
      rst_n = 1'b1;
      tick();

      // PPS mode on ch0
      inc   = 10;
      t_sec = 48'h12345677;
      t_ns  = 999_999_980;
      setcfg(48'h12345678, 0, 0, 100_000_000);
      ch_en   = 4'b0001;
      ch_load = 4'b0001;
      tick();
      chk("pps_armed", pulse_o[0], 0);
      tick();
      chk("pps_before", pulse_o[0], 0);
      tick();
      chk("pps_rise", pulse_o[0], 1);
      chk("pps_evt", evt_o[0], 1);
      tick();
      chk("pps_evt_once", evt_o[0], 0);
      chk("pps_hold", pulse_o[0], 1);
      t_sec = 48'h12345678;
      t_ns  = 99_999_990;
      tick();
      chk("pps_prefall", pulse_o[0], 1);
      tick();
      chk("pps_fall", pulse_o[0], 0);
      t_ns = 999_999_990;
      tick();
      chk("pps_before2", pulse_o[0], 0);
      tick();
      chk("pps_rise2", pulse_o[0], 1);
      chk("pps_evt2", evt_o[0], 1);
      chk("pps_missed", missed_o[0], 0);
      ch_en = 4'b0000;
      tick();
      chk("en_drop", pulse_o[0], 0);

      // fast periodic on ch1
      inc   = 100_000;
      t_sec = 5;
      t_ns  = 0;
      setcfg(5, 2_000_000, 1_000_000, 500_000);
      ch_en   = 4'b0010;
      ch_load = 4'b0010;
      tick();
      ne = 0;
      nh = 0;
      for (int i = 0; i < 118; i++) begin
         pns = t_ns;
         tick();
         if (evt_o[1]) begin
            ne++;
            chk("fast_phase", 64'(pns % 1_000_000), 0);
         end
         if (pulse_o[1]) nh++;
      end
      chk("fast_evt_cnt", ne, 10);
      chk("fast_high_cnt", nh, 50);
      chk("fast_missed", missed_o[1], 0);

      // forward step of +5.25 s mid-pulse
      tick();
      tick();
      chk("pre_step_high", pulse_o[1], 1);
      t_sec    = 10;
      t_ns     = 262_100_000;
      inc      = 0;
      rtc_step = 1'b1;
      tick();
      chk("step_drop", pulse_o[1], 0);
      ne = 0;
      nh = 0;
      for (int i = 0; i < 6000; i++) begin
         tick();
         if (evt_o[1]) ne++;
         if (pulse_o[1]) nh++;
      end
      chk("catchup_no_evt", ne, 0);
      chk("catchup_no_pulse", nh, 0);
      chk("step_missed", missed_o[1], 1);
      inc  = 100_000;
      t_ns = 262_900_000;
      tick();
      chk("post_step_before", pulse_o[1], 0);
      tick();
      chk("post_step_rise", pulse_o[1], 1);
      chk("post_step_evt", evt_o[1], 1);
      ch_en = 4'b0000;
      tick();
      chk("ch1_off", pulse_o[1], 0);

      // width 0 on ch2
      inc   = 1000;
      t_sec = 20;
      t_ns  = 0;
      setcfg(20, 5000, 10_000, 0);
      ch_en   = 4'b0100;
      ch_load = 4'b0100;
      tick();
      ne  = 0;
      nh  = 0;
      dbl = 0;
      pp  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (evt_o[2]) ne++;
         if (pulse_o[2]) nh++;
         if (pulse_o[2] && pp) dbl++;
         pp = pulse_o[2];
      end
      chk("w0_evt_cnt", ne, 3);
      chk("w0_high_cnt", nh, 3);
      chk("w0_single", dbl, 0);
      ch_en = 4'b0000;
      tick();

      // illegal configs on ch3
      t_sec = 30;
      t_ns  = 0;
      setcfg(30, 0, 1_000_000_000, 100);
      ch_en   = 4'b1000;
      ch_load = 4'b1000;
      tick();
      chk("bad_period_err", cfg_err_o[3], 1);
      repeat (3) tick();
      chk("bad_period_idle", pulse_o[3], 0);
      setcfg(30, 0, 1000, 1000);
      ch_load = 4'b1000;
      tick();
      chk("bad_width_err", cfg_err_o[3], 1);
      repeat (2) tick();
      chk("bad_width_idle", pulse_o[3], 0);
      setcfg(30, 1_000_000_000, 10_000, 0);
      ch_load = 4'b1000;
      tick();
      chk("bad_ns_err", cfg_err_o[3], 1);
      t_ns = 0;
      setcfg(30, 10_000, 10_000, 2000);
      ch_load = 4'b1000;
      tick();
      chk("good_clr_err", cfg_err_o[3], 0);
      chk("good_armed", pulse_o[3], 0);
      repeat (9) tick();
      chk("good_before", pulse_o[3], 0);
      tick();
      chk("good_rise", pulse_o[3], 1);
      chk("good_evt", evt_o[3], 1);
      tick();
      chk("good_hold", pulse_o[3], 1);
      tick();
      chk("good_fall", pulse_o[3], 0);

      // sticky flag on ch0, then async reset mid-pulse
      setcfg(0, 0, 1_000_000_000, 0);
      ch_load = 4'b0001;
      tick();
      chk("ch0_err", cfg_err_o[0], 1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (pulse_o[3]) found = 1'b1;
      end
      chk("ch3_rehigh", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_pulse", pulse_o, 0);
      chk("rst_async_missed", missed_o, 0);
      chk("rst_async_err", cfg_err_o, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
